// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants for the MIPS pipeline
package regfile_pkg;
    localparam int unsigned REG_NUM      = 32;
    localparam int unsigned REG_NUM_LOG2 = 5;
    localparam int unsigned REG_W        = 32;
    localparam logic        WRITE_ENABLE = 1'b1;
    localparam logic        READ_ENABLE  = 1'b1;
endpackage

// File: rtl/regfile_rport.sv
// regfile_rport: combinational read-port mux with optional same-cycle write bypass
module regfile_rport
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_NUM_LOG2,
    parameter int unsigned DATA_W = REG_W,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] arr_data,
    output logic [DATA_W-1:0] rdata
);
    logic hit;
    always_comb begin
        // compare uses only the address so it runs in parallel with wdata
        hit   = BYPASS && (we == WRITE_ENABLE) && (waddr == raddr);
        rdata = (!rst || re != READ_ENABLE || raddr == '0) ? '0 :
                hit ? wdata : arr_data;
    end
endmodule

// File: rtl/regfile.sv
// regfile: 32x32 MIPS register file, $0 hardwired, two bypassed read ports plus debug port
module regfile
    import regfile_pkg::*;
#(
    parameter int unsigned NREG   = REG_NUM,
    parameter int unsigned ADDR_W = REG_NUM_LOG2,
    parameter int unsigned DATA_W = REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (we == WRITE_ENABLE && waddr != '0) regs_d[waddr] = wdata;
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) regs_q <= '{default: '0};
        else regs_q <= regs_d;
    end

    regfile_rport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BYPASS(1'b1)) u_rp1 (
        .rst(rst), .re(re1), .raddr(raddr1), .we(we), .waddr(waddr),
        .wdata(wdata), .arr_data(regs_q[raddr1]), .rdata(rdata1)
    );

    regfile_rport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BYPASS(1'b1)) u_rp2 (
        .rst(rst), .re(re2), .raddr(raddr2), .we(we), .waddr(waddr),
        .wdata(wdata), .arr_data(regs_q[raddr2]), .rdata(rdata2)
    );

    // debug view shows committed state only
    regfile_rport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BYPASS(1'b0)) u_dbg (
        .rst(rst), .re(1'b1), .raddr(dbg_addr), .we(we), .waddr(waddr),
        .wdata(wdata), .arr_data(regs_q[dbg_addr]), .rdata(dbg_data)
    );
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile
module tb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    int total = 0;
    int bad   = 0;

    regfile dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1;
        waddr = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'h5555_5555;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5; dbg_addr = 5'd5;
        #1;
        chk("rst_rd1", rdata1, 32'h0);
        chk("rst_rd2", rdata2, 32'h0);
        chk("rst_dbg", dbg_data, 32'h0);
        @(posedge clk);
        #1;
        we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_write_blocked", dbg_data, 32'h0);

        wr(5'd5, 32'h0000_1234);
        dbg_addr = 5'd5;
        #1;
        chk("dbg5_written", dbg_data, 32'h0000_1234);
        #2 rst = 1'b0;
        #1;
        chk("async_clear_dbg5", dbg_data, 32'h0);
        chk("async_clear_rd1", rdata1, 32'h0);
        wr(5'd6, 32'h0000_0066);
        rst = 1'b1;
        dbg_addr = 5'd6;
        #1;
        chk("write_in_rst_lost", dbg_data, 32'h0);
        dbg_addr = 5'd5;
        #1;
        chk("dbg5_stays_clear", dbg_data, 32'h0);

        wr(5'd7, 32'hDEAD_BEEF);
        re1 = 1'b1; raddr1 = 5'd7;
        #1;
        chk("readback7", rdata1, 32'hDEAD_BEEF);
        re1 = 1'b0;
        #1;
        chk("re1_off", rdata1, 32'h0);
        re2 = 1'b0; raddr2 = 5'd7;
        #1;
        chk("re2_off", rdata2, 32'h0);
        re1 = 1'b1; re2 = 1'b1;

        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        raddr1 = 5'd0; raddr2 = 5'd0; dbg_addr = 5'd0;
        #1;
        chk("zero_same_rd1", rdata1, 32'h0);
        chk("zero_same_rd2", rdata2, 32'h0);
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        chk("zero_next_rd1", rdata1, 32'h0);
        chk("zero_next_rd2", rdata2, 32'h0);
        chk("zero_next_dbg", dbg_data, 32'h0);

        wr(5'd3, 32'h0000_0011);
        we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0022;
        raddr1 = 5'd3; raddr2 = 5'd3; dbg_addr = 5'd3;
        #1;
        chk("bypass_rd1", rdata1, 32'h0000_0022);
        chk("bypass_rd2", rdata2, 32'h0000_0022);
        chk("bypass_dbg_old", dbg_data, 32'h0000_0011);
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        chk("post_bypass_rd1", rdata1, 32'h0000_0022);
        chk("post_bypass_rd2", rdata2, 32'h0000_0022);
        chk("post_bypass_dbg", dbg_data, 32'h0000_0022);

        wr(5'd4, 32'h0000_0044);
        we = 1'b1; waddr = 5'd9; wdata = 32'h0000_00AB;
        raddr1 = 5'd4; raddr2 = 5'd9;
        #1;
        chk("indep_rd1_old4", rdata1, 32'h0000_0044);
        chk("indep_rd2_byp9", rdata2, 32'h0000_00AB);
        @(posedge clk);
        #1;
        we = 1'b0;

        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h0101_0101);
        for (int i = 1; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(32 - i);
            dbg_addr = 5'(i);
            #1;
            v = 32'(i) * 32'h0101_0101;
            chk($sformatf("sweep_rd1_%0d", i), rdata1, v);
            chk($sformatf("sweep_dbg_%0d", i), dbg_data, v);
            v = 32'(32 - i) * 32'h0101_0101;
            chk($sformatf("sweep_rd2_%0d", 32 - i), rdata2, v);
        end
        dbg_addr = 5'd0; raddr1 = 5'd0;
        #1;
        chk("sweep_r0_dbg", dbg_data, 32'h0);
        chk("sweep_r0_rd1", rdata1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the five-stage MIPS pipeline: the responder on the ID-stage read interface (two operand read ports) and the sink of the WB-stage write port. Holds 32 × 32-bit registers with `$0` hardwired to zero. Provides same-cycle write-to-read bypass, so the ID-stage forwarding network only needs to cover EX and MEM. A third read port exposes register contents to the testbench and debug logic.

## Interface
- `NREG`, 32, number of architectural registers; must be a power of two.
- `ADDR_W`, 5, register address width; equals log2(`NREG`).
- `DATA_W`, 32, register data width.
- `clk`  in  1  pipeline clock; all register updates occur on its rising edge.
- `rst`  in  1  reset: asynchronous and active-low.
- `we`  in  1  write enable from WB (`WriteEnable`).
- `waddr`  in  ADDR_W  write register address.
- `wdata`  in  DATA_W  write data.
- `re1`  in  1  read enable, port 1 (`ReadEnable`).
- `raddr1`  in  ADDR_W  read address, port 1.
- `rdata1`  out  DATA_W  read data, port 1; combinational.
- `re2`  in  1  read enable, port 2.
- `raddr2`  in  ADDR_W  read address, port 2.
- `rdata2`  out  DATA_W  read data, port 2; combinational.
- `dbg_addr`  in  ADDR_W  debug read address; always enabled.
- `dbg_data`  out  DATA_W  debug read data; combinational; no bypass.

## Operation
- Storage: `NREG` entries of `DATA_W` bits each. Entry 0 is never written and always reads as `ZeroWord`.
- Write: on the rising edge of `clk` with `rst` high, `we`=1 and `waddr`≠0, store `wdata` in `regs[waddr]`.
  - `we`=1 with `waddr`=0 is silently dropped.
- Read ports 1 and 2 are identical and independent. For port n, evaluate in priority order:
  1. `rst` low → `ZeroWord`.
  2. `ren`=0 → `ZeroWord`.
  3. `raddrn`=0 → `ZeroWord`.
  4. `we`=1 and `waddr`=`raddrn` → `wdata` (bypass).
  5. Otherwise → `regs[raddrn]`.
- Both ports may read the same address, including the bypassed address, in the same cycle. Both return identical data.
- Debug port: returns `regs[dbg_addr]`, or `ZeroWord` when `rst` is low or `dbg_addr`=0. It has no bypass, so it shows committed state only.
- Reset: asserting `rst` low clears every entry to zero immediately, without waiting for a clock edge. Writes are blocked while `rst` is low.
  - Deassertion is synchronised upstream. The first write is accepted on the first rising edge with `rst` high.
- No internal state other than the storage array. There are no error conditions.

## Timing
- Read latency: 0 cycles (combinational from address, enable and write inputs).
- Write latency: 1 edge. The value is visible through the bypass in the same cycle and through storage from the following cycle.
- Output values while `rst` is low: `rdata1`=`rdata2`=`dbg_data`=0.
- Critical path: `waddr`/`wdata` → bypass compare → `rdata` mux → ID forwarding mux.
  - The bypass compare uses only `waddr`, not `wdata`, so the compare proceeds in parallel with the data path.
- Reset mid-cycle during an active write: the write is lost and the entry stays 0.

## Structure
- Shared constants live in `defines.v`: `RegBus`, `RegAddrBus`, `RegNum`, `RegNumLog2`, `ZeroWord`, `NOPRegAddr`, `WriteEnable`, `ReadEnable`. No new typedefs are needed.
- One natural sub-module, `regfile_rport`:
  - Combinational read-port mux (reset/enable/zero-address/bypass/array select).
  - Instantiated twice, with the bypass on.
  - The debug path reuses it with the bypass disabled via its parameter `BYPASS`=0 and enable tied to 1.
- The top level holds the storage array, the write logic and the asynchronous clear.

## Test plan
- Reset: write `$5`=0x1234, pulse `rst` low mid-cycle → `dbg_data` at addr 5 goes to 0 before the next edge; all reads return 0 while `rst` is low.
- Write/readback: write `$7`=0xDEADBEEF, next cycle `re1`=1, `raddr1`=7 → `rdata1`=0xDEADBEEF; with `re1`=0 → 0.
- Zero register: `we`=1, `waddr`=0, `wdata`=0xFFFFFFFF; read `raddr1`=`raddr2`=0 in the same and next cycle → 0 on both; `dbg_data` at 0 → 0.
- Bypass: `$3` holds 0x11; same cycle `we`=1, `waddr`=3, `wdata`=0x22, both ports read 3 → both return 0x22 and `dbg_data`=0x11; next cycle all three return 0x22.
- Independence: `raddr1`=4 and `raddr2`=9 while writing `$9`=0xAB → `rdata1`=old `$4`, `rdata2`=0xAB.
- Sweep: write `$i`=i×0x01010101 for i=1..31, then read all pairs (i, 32−i) → values match; `$0` stays 0.
